// File: rtl/rs_pkg.sv
// Shared definitions for the rs_square shift-add squarer: default operand
// width, controller state encoding and iteration-counter sizing.
package rs_pkg;

  // Default root operand width in bits (legal range 2..16).
  localparam int RS_N_DEFAULT = 10;

  // Controller states; the encoding is fixed so busy/done decode stays trivial.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } rs_state_t;

  // Iteration counter width: clog2(N) bits, enough to index every multiplier bit.
  function automatic int rs_cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int RS_CNT_W_DEFAULT = rs_cnt_w(RS_N_DEFAULT);

endpackage

// File: rtl/rs_square_if.sv
// Request/result bundle of the squarer. The requester drives start/data_in,
// the squarer returns busy, done and the 2N-bit result.
interface rs_square_if #(
  parameter int N = 10
);

  logic           start;
  logic [N-1:0]   data_in;
  logic           busy;
  logic           done;
  logic [2*N-1:0] data_out;

  modport master (
    output start,
    output data_in,
    input  busy,
    input  done,
    input  data_out
  );

  modport slave (
    input  start,
    input  data_in,
    output busy,
    output done,
    output data_out
  );

endinterface

// File: rtl/rs_square_du.sv
// Datapath of the squarer: operand registers X and Y, the 2N-bit
// accumulator and the result register. Sequenced entirely by the
// load / step / ldo strobes from the controller.
module rs_square_du
  import rs_pkg::*;
#(
  parameter  int N  = RS_N_DEFAULT,
  localparam int CW = rs_cnt_w(N)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic           ldo,
  input  logic [CW-1:0]  idx,
  input  logic [N-1:0]   data_in,
  output logic [2*N-1:0] data_out
);

  logic [N-1:0]   x_r;
  logic [N-1:0]   y_r;
  logic [2*N-1:0] acc_r;
  logic [2*N-1:0] addend_s;
  logic [2*N-1:0] acc_next_s;

  // Partial product for the current multiplier bit; the sum of all partial
  // products is X*Y < 2^(2N), so the 2N-bit add never carries out.
  always_comb begin
    addend_s   = {(2*N){1'b0}};
    acc_next_s = acc_r;
    if (y_r[idx]) begin
      addend_s = {{N{1'b0}}, x_r} << idx;
    end else begin
      addend_s = {(2*N){1'b0}};
    end
    acc_next_s = acc_r + addend_s;
  end

  // Operand capture, shift-add accumulation and final result load.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_r      <= {N{1'b0}};
      y_r      <= {N{1'b0}};
      acc_r    <= {(2*N){1'b0}};
      data_out <= {(2*N){1'b0}};
    end else begin
      if (load) begin
        x_r   <= data_in;
        y_r   <= data_in;
        acc_r <= {(2*N){1'b0}};
      end else if (step) begin
        acc_r <= acc_next_s;
      end else begin
        acc_r <= acc_r;
      end
      // The last step's contribution is folded in here, so data_out gets
      // the complete square on the same edge as the final accumulation.
      if (ldo) begin
        data_out <= acc_next_s;
      end else begin
        data_out <= data_out;
      end
    end
  end

endmodule

// File: rtl/rs_square.sv
// Sequential squarer: data_out = data_in * data_in via N shift-add steps.
// Holds the IDLE/CALC/DONE controller and iteration counter, and drives the
// rs_square_du datapath with load/step/ldo strobes.
module rs_square
  import rs_pkg::*;
#(
  parameter int N = RS_N_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  rs_square_if.slave bus
);

  localparam int            CW   = rs_cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  rs_state_t     state_r;
  rs_state_t     state_s;
  logic [CW-1:0] cnt_r;
  logic          load_s;
  logic          step_s;
  logic          ldo_s;

  // Controller state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Iteration counter: cleared on accept, advanced once per shift-add step.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (load_s) begin
      cnt_r <= {CW{1'b0}};
    end else if (step_s) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Next-state and strobe decode; start is only looked at in IDLE.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    ldo_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          load_s  = 1'b1;
          state_s = CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        step_s = 1'b1;
        if (cnt_r == LAST) begin
          ldo_s   = 1'b1;
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Status flags come straight from the registered state.
  assign bus.busy = (state_r == CALC);
  assign bus.done = (state_r == DONE);

  rs_square_du #(
    .N (N)
  ) u_du (
    .clock    (clock),
    .reset    (reset),
    .load     (load_s),
    .step     (step_s),
    .ldo      (ldo_s),
    .idx      (cnt_r),
    .data_in  (bus.data_in),
    .data_out (bus.data_out)
  );

endmodule

// File: tb/tb_rs_square.sv
// Self-checking bench for rs_square: an N=10 and an N=4 instance, compared
// against plain integer squaring and a fixed N-edge start-to-result latency.
module tb_rs_square;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  rs_square_if #(.N(10)) bus10 ();
  rs_square_if #(.N(4))  bus4 ();

  rs_square #(.N(10)) dut10 (.clock(clock), .reset(reset), .bus(bus10.slave));
  rs_square #(.N(4))  dut4  (.clock(clock), .reset(reset), .bus(bus4.slave));

  always #5 clock = ~clock;

  // Advance one clock edge and settle 1ns past it.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc = cyc + 1;
  endtask

  // Integer square root used for the round-trip check.
  function automatic int isqrt(input longint x);
    longint lo = 0;
    longint hi = 65536;
    longint mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid - 1;
    end
    return int'(lo);
  endfunction

  // Issue one request to the N=10 unit; lat = edges from accept to done (-1 on timeout).
  task automatic run10(input int v, output int lat, output longint res);
    bus10.data_in = v[9:0];
    bus10.start   = 1'b1;
    tick();
    bus10.start   = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus10.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    res = longint'(bus10.data_out);
  endtask

  // Same for the N=4 unit.
  task automatic run4(input int v, output int lat, output longint res);
    bus4.data_in = v[3:0];
    bus4.start   = 1'b1;
    tick();
    bus4.start   = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus4.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    res = longint'(bus4.data_out);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_cmp += 6;
    if (bus10.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy10 got %b want 0", bus10.busy); end
    if (bus10.done !== 1'b0) begin n_bad++; $display("FAIL reset_done10 got %b want 0", bus10.done); end
    if (bus10.data_out !== 20'd0) begin n_bad++; $display("FAIL reset_dout10 got %0d want 0", bus10.data_out); end
    if (bus4.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy4 got %b want 0", bus4.busy); end
    if (bus4.done !== 1'b0) begin n_bad++; $display("FAIL reset_done4 got %b want 0", bus4.done); end
    if (bus4.data_out !== 8'd0) begin n_bad++; $display("FAIL reset_dout4 got %0d want 0", bus4.data_out); end
  endtask

  // One N=10 operation with latency, value, single-cycle done and busy checks.
  task automatic check_op10(input string name, input int v);
    int     lat;
    longint res;
    longint exp_v;
    exp_v = longint'(v) * longint'(v);
    run10(v, lat, res);
    n_cmp += 3;
    if (lat !== 10) begin n_bad++; $display("FAIL %s_latency v=%0d got %0d want 10", name, v, lat); end
    if (res !== exp_v) begin n_bad++; $display("FAIL %s_value v=%0d got %0d want %0d", name, v, res, exp_v); end
    tick();
    if (bus10.done !== 1'b0 || bus10.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_done_width v=%0d done=%b busy=%b want 0/0", name, v, bus10.done, bus10.busy);
    end
  endtask

  task automatic test_corners();
    check_op10("zero", 0);
    check_op10("max", 1023);
    check_op10("half", 512);
    check_op10("one", 1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      check_op10("rand", int'($urandom_range(0, 1023)));
    end
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    int lat;
    t1 = -1;
    t2 = -1;
    bus10.data_in = 10'd3;
    bus10.start   = 1'b1;
    tick();
    bus10.data_in = 10'd5;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus10.done === 1'b1) begin
        t1 = cyc;
        lat = k;
        break;
      end
    end
    n_cmp += 2;
    if (lat !== 10) begin n_bad++; $display("FAIL b2b_latency got %0d want 10", lat); end
    if (bus10.data_out !== 20'd9) begin n_bad++; $display("FAIL b2b_first got %0d want 9", bus10.data_out); end
    tick();
    tick();
    bus10.start   = 1'b0;
    bus10.data_in = 10'd7;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus10.done === 1'b1) begin
        t2 = cyc;
        break;
      end
    end
    n_cmp += 3;
    if (bus10.data_out !== 20'd25) begin n_bad++; $display("FAIL b2b_second got %0d want 25", bus10.data_out); end
    if (t1 < 0 || t2 - t1 !== 12) begin n_bad++; $display("FAIL b2b_spacing got %0d want 12", t2 - t1); end
    tick();
    tick();
    if (bus10.busy !== 1'b0 || bus10.data_out !== 20'd25) begin
      n_bad++;
      $display("FAIL b2b_no_queue busy=%b dout=%0d want 0/25", bus10.busy, bus10.data_out);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    bus10.data_in = 10'd700;
    bus10.start   = 1'b1;
    tick();
    bus10.start   = 1'b0;
    repeat (4) tick();
    n_cmp += 1;
    if (bus10.busy !== 1'b1) begin n_bad++; $display("FAIL midreset_busy got %b want 1", bus10.busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (bus10.done === 1'b1) seen = 1'b1;
      tick();
    end
    n_cmp += 3;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL midreset_done got 1 want 0"); end
    if (bus10.data_out !== 20'd0) begin n_bad++; $display("FAIL midreset_dout got %0d want 0", bus10.data_out); end
    if (bus10.busy !== 1'b0) begin n_bad++; $display("FAIL midreset_idle busy=%b want 0", bus10.busy); end
    check_op10("after_reset", 700);
  endtask

  task automatic test_sweep();
    int     lat;
    longint res;
    for (int v = 0; v < 1024; v++) begin
      run10(v, lat, res);
      n_cmp += 3;
      if (lat !== 10) begin n_bad++; $display("FAIL sweep_latency v=%0d got %0d want 10", v, lat); end
      if (res !== longint'(v) * longint'(v)) begin
        n_bad++;
        $display("FAIL sweep_value v=%0d got %0d want %0d", v, res, longint'(v) * longint'(v));
      end
      if (isqrt(res) !== v) begin n_bad++; $display("FAIL sweep_sqrt v=%0d got %0d want %0d", v, isqrt(res), v); end
      tick();
    end
  endtask

  task automatic test_n4();
    int     lat;
    longint res;
    for (int k = 0; k < 16; k++) begin
      int v;
      v = (k == 0) ? 15 : int'($urandom_range(0, 15));
      run4(v, lat, res);
      n_cmp += 3;
      if (lat !== 4) begin n_bad++; $display("FAIL n4_latency v=%0d got %0d want 4", v, lat); end
      if (res !== longint'(v * v)) begin n_bad++; $display("FAIL n4_value v=%0d got %0d want %0d", v, res, v * v); end
      tick();
      if (bus4.done !== 1'b0) begin n_bad++; $display("FAIL n4_done_width v=%0d got %b want 0", v, bus4.done); end
    end
  endtask

  initial begin
    bus10.start   = 1'b0;
    bus10.data_in = 10'd0;
    bus4.start    = 1'b0;
    bus4.data_in  = 4'd0;
    test_reset();
    test_corners();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    test_n4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rs_square.md
RS_SQUARE -- requirements
Module: rs_square

Interface
REQ-001 SHALL have parameter N, default 10, root operand width in bits (legal range 2..16).
REQ-002 SHALL have port clock, input, 1, single rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to square data_in; sampled only in IDLE.
REQ-005 SHALL have port data_in, input, N, unsigned root operand; captured on the accepting edge.
REQ-006 SHALL have port busy, output, 1, high while in CALC.
REQ-007 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-008 SHALL have port data_out, output, 2N, unsigned square result; holds until next completion.

Function
REQ-009 SHALL compute data_out = data_in * data_in exactly, with no truncation, for all 2^N inputs.
REQ-010 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-011 SHALL, in IDLE with start=1 at edge E0, capture the multiplicand X=data_in and the multiplier Y=data_in, clear accumulator ACC (2N bits), set iteration counter i=0, and enter CALC.
REQ-012 SHALL, in CALC at each edge, perform one shift-add step: if Y[i]=1 then ACC <= ACC + (X << i), computed in 2N bits; i <= i+1.
REQ-013 SHALL, on the edge where i=N-1 (edge EN, N edges after E0), load data_out with the final ACC value including that step, and enter DONE.
REQ-014 SHALL assert done for exactly the one cycle following EN, then return to IDLE at E(N+1).
REQ-015 SHALL have a fixed latency: done high in the cycle after EN, so a new result is available N cycles after the start edge.
REQ-016 SHALL ignore start while in CALC or DONE; no queuing; captured operands remain unaffected by data_in changes after E0.
REQ-017 SHALL accept start=1 held continuously as a new request at each IDLE visit, giving one result every N+2 cycles.
REQ-018 SHALL guarantee that intermediate ACC never exceeds 2N bits; no carry out is generated or needed.
REQ-019 SHALL keep busy = (state==CALC) and done = (state==DONE), both decoded from the registered state, with no combinational path from start.
REQ-020 SHALL change data_out only at EN; data_out holds its value through IDLE and the following operation.

Reset
REQ-021 SHALL, on reset sampled high at a clock edge, set the state to IDLE, busy=0, done=0, data_out=0, ACC=0, i=0, and X=Y=0.
REQ-022 SHALL, on reset asserted mid-CALC, abort the operation without asserting done and without updating data_out from the partial result.
REQ-023 SHALL give reset priority over start at the same edge.

Structure
REQ-024 SHALL split into a controller (the FSM and counter) and a datapath sub-module rs_square_du holding X, Y, ACC and data_out, driven by load, step and ldo strobes, mirroring the team's CU/DU partition.
REQ-025 SHALL place the FSM state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the default N in a shared package rs_pkg used by both the controller and the datapath.
REQ-026 SHALL size the iteration counter at clog2(N) bits, defined in rs_pkg.

Verification
REQ-027 SHALL be verified so that: data_in=0, start pulse -> done after 10 cycles, data_out=0.
REQ-028 SHALL be verified so that: data_in=1023 -> data_out=1046529; data_in=512 -> 262144; data_in=1 -> 1.
REQ-029 SHALL be verified so that: start held high with data_in=3, then 5 -> results 9, then 25, with done pulses spaced 12 cycles apart; data_in changed during CALC has no effect.
REQ-030 SHALL be verified so that: reset asserted at the 5th CALC cycle of data_in=700 -> no done, data_out=0; a following data_in=700 request -> data_out=490000.
REQ-031 SHALL be verified so that: an exhaustive sweep of 0..1023 matches a reference model, and a round trip through the team's square-root unit returns the original root.
REQ-032 SHALL be verified so that: with N=4, data_in=15 -> data_out=225 after 4 cycles.
